// File: rtl/gpa_fhdo_seq_pkg.sv
// Shared definitions for the GPA-FHDO DAC/ADC update sequencer.
package gpa_fhdo_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FINISH
    } state_e;

    // DAC register address used for every channel write
    localparam logic [1:0] DAC_ADDR = 2'b10;

    // Bit-field positions inside the 32-bit SPI word
    localparam int ADC_SEL_BIT = 30;
    localparam int BCAST_BIT   = 24;
    localparam int ADDR_HI     = 19;
    localparam int ADDR_LO     = 16;
    localparam int CMD_LO      = 8;

    localparam int CH_MAX = 4;

endpackage

// File: rtl/gpa_fhdo_word_fmt.sv
// Combinational builder for the 32-bit SPI word (DAC write or ADC readback).
module gpa_fhdo_word_fmt
    import gpa_fhdo_seq_pkg::*;
(
    input  logic [1:0]  ch_i,
    input  logic [15:0] code_i,
    input  logic        adc_i,
    input  logic [15:0] cmd_i,
    output logic [31:0] word_o
);

    // ADC words carry only the select bit and command; DAC words carry address and code
    always_comb begin
        word_o = '0;
        if (adc_i) begin
            word_o[ADC_SEL_BIT]     = 1'b1;
            word_o[CMD_LO +: 16]    = cmd_i;
        end else begin
            word_o[BCAST_BIT]       = 1'b0;
            word_o[ADDR_HI:ADDR_LO] = {DAC_ADDR, ch_i};
            word_o[15:0]            = code_i;
        end
    end

endmodule

// File: rtl/gpa_fhdo_seq.sv
// Update sequencer: walks enabled DAC channels in ascending order, then an
// optional ADC readback, handshaking each word against the SPI interface busy flag.
module gpa_fhdo_seq
    import gpa_fhdo_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CH_NUM         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ch_data_i,
    input  logic [3:0]  ch_en_i,
    input  logic        adc_en_i,
    input  logic [15:0] adc_cmd_i,
    input  logic        update_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        iface_busy_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q;
    logic [63:0]   data_q;
    logic [3:0]    en_q;
    logic          adc_q;
    logic [15:0]   cmd_q;
    logic [2:0]    ch_idx_q;
    logic [1:0]    cur_ch_q;
    logic          cur_adc_q;
    logic          adc_done_q;
    logic          pend_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   word_q;
    logic          valid_q, busy_q, done_q, overrun_q, timeout_q;

    logic          sel_found;
    logic [1:0]    sel_ch;
    logic [15:0]   sel_code;
    logic [31:0]   sel_word;

    // Lowest enabled channel at or above the current index
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (en_q[i] && (3'(i) >= ch_idx_q)) begin
                sel_found = 1'b1;
                sel_ch    = 2'(i);
            end
        end
        sel_code = data_q[{sel_ch, 4'b0000} +: 16];
    end

    gpa_fhdo_word_fmt u_fmt (
        .ch_i   (sel_ch),
        .code_i (sel_code),
        .adc_i  (~sel_found),
        .cmd_i  (cmd_q),
        .word_o (sel_word)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            en_q       <= '0;
            adc_q      <= 1'b0;
            cmd_q      <= '0;
            ch_idx_q   <= '0;
            cur_ch_q   <= '0;
            cur_adc_q  <= 1'b0;
            adc_done_q <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            // Strobes arriving mid-sequence collapse into a single pending restart
            if (update_i && busy_q) begin
                overrun_q <= 1'b1;
                pend_q    <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (update_i || pend_q) begin
                        data_q     <= ch_data_i;
                        en_q       <= ch_en_i;
                        adc_q      <= adc_en_i;
                        cmd_q      <= adc_cmd_i;
                        ch_idx_q   <= '0;
                        adc_done_q <= 1'b0;
                        pend_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (sel_found || (adc_q && !adc_done_q)) begin
                        word_q    <= sel_word;
                        valid_q   <= 1'b1;
                        cur_ch_q  <= sel_ch;
                        cur_adc_q <= ~sel_found;
                        state_q   <= S_ISSUE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (iface_busy_i) begin
                        state_q <= S_WAIT_LO;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!iface_busy_i) begin
                        if (cur_adc_q) adc_done_q <= 1'b1;
                        else           ch_idx_q   <= {1'b0, cur_ch_q} + 3'd1;
                        state_q <= S_SELECT;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_o    = word_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/gpa_fhdo_seq.md
GPA_FHDO_SEQ -- requirements
Module: gpa_fhdo_seq

Interface
REQ-001 Parameters: TIMEOUT_CYCLES, default 1023, max cycles to wait for busy_i to rise after issue; CH_NUM, default 4, DAC channel count (fixed 4 in this revision).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ch_data_i  input  64  four 16-bit DAC codes, ch0 in [15:0] through ch3 in [63:48].
REQ-005 ch_en_i  input  4  per-channel enable mask; disabled channels are skipped.
REQ-006 adc_en_i  input  1  append one ADC readback transfer after the DAC writes.
REQ-007 adc_cmd_i  input  16  ADC command word.
REQ-008 update_i  input  1  single-cycle strobe; starts an update sequence.
REQ-009 data_o  output  32  word to the SPI interface; valid_o  output  1  one-cycle issue strobe.
REQ-010 iface_busy_i  input  1  busy flag from the SPI interface.
REQ-011 busy_o, done_o, overrun_o, timeout_o  output  1 each  sequencer busy, one-cycle completion pulse, sticky overrun, sticky timeout.

Function
REQ-012 FSM states: IDLE, SELECT, ISSUE, WAIT_HI, WAIT_LO, FINISH.
REQ-013 IDLE + update_i: snapshot ch_data_i, ch_en_i, adc_en_i, adc_cmd_i; ch_idx=0; go to SELECT next cycle.
REQ-014 SELECT: first enabled channel >= ch_idx -> ISSUE; none left and adc snapshot set and not yet done -> ISSUE (ADC); otherwise -> FINISH.
REQ-015 DAC word: bits[31:25]=0, [24]=0 (no broadcast), [23:20]=0, [19:18]=2'b10, [17:16]=channel, [15:0]=code.
REQ-016 ADC word: bit[30]=1, [23:8]=adc_cmd, all other bits 0.
REQ-017 ISSUE: valid_o=1 for exactly one cycle with data_o stable; go to WAIT_HI; timeout counter cleared.
REQ-018 data_o SHALL hold the last issued word until the next ISSUE.
REQ-019 WAIT_HI: wait for iface_busy_i=1, then WAIT_LO; if counter reaches TIMEOUT_CYCLES first, set timeout_o, abort to FINISH.
REQ-020 WAIT_LO: on iface_busy_i=0, advance ch_idx past issued channel (or mark ADC done), return to SELECT; no timeout in this state.
REQ-021 FINISH: done_o=1 for one cycle, then IDLE.
REQ-022 busy_o=1 in every state except IDLE.
REQ-023 Transfer order: ascending channel index, ADC last; at most one ADC transfer per sequence.
REQ-024 update_i while busy_o=1: set overrun_o and latch one pending request; further strobes are merged into it.
REQ-025 Pending request: FINISH -> IDLE, then start a new sequence in the IDLE cycle with inputs sampled that cycle.
REQ-026 ch_en_i=0 and adc_en_i=0: IDLE -> SELECT -> FINISH; no valid_o; done_o pulses.
REQ-027 overrun_o and timeout_o are cleared only by rst.

Reset
REQ-028 rst asserted: state=IDLE; valid_o, busy_o, done_o, overrun_o, timeout_o=0; data_o=0; pending, indices, counters cleared.
REQ-029 rst mid-sequence: immediate abort, no further valid_o, no done_o.

Structure
REQ-030 Shared package: state encoding, DAC address constant 2'b10, bit-field position constants ([30] adc select, [24] broadcast, [19:16] address).
REQ-031 One sub-module, gpa_fhdo_word_fmt: combinational word builder (channel, code, adc flag, cmd -> 32-bit word).

Verification
REQ-032 All enabled, codes 0x1111/0x2222/0x3333/0x4444; iface model busy 3-cycle delay, 40 cycles long -> words 0x00081111, 0x00092222, 0x000A3333, 0x000B4444 in order; done_o once.
REQ-033 ch_en_i=4'b1010, adc_en_i=1, adc_cmd_i=0xD000 -> words 0x0009xxxx, 0x000Bxxxx, 0x40D00000; done_o once.
REQ-034 Second update_i during channel 1 -> overrun_o=1; exactly one further sequence after done_o.
REQ-035 Model never raises busy -> timeout_o=1 after TIMEOUT_CYCLES, done_o pulses, busy_o=0.
REQ-036 rst asserted in WAIT_LO -> all outputs 0 next cycle; new update_i after release restarts from ch0.
